// File: rtl/fpu_add_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// fpu_add_seq_ctrl_if
//
// Requester-side bundle for the shared FP add/sub sequencer. It carries the
// request channel (valid / accept strobe / operands / op select) and the
// response channel (valid / ready / result / flags) for all NREQ requesters.
// Signal suffixes are written from the sequencer's point of view.
//
// Signals:
//   req_valid_i  [NREQ]            request valid per requester
//   req_ready_o  [NREQ]            one-cycle grant/accept strobe per requester
//   req_opa_i    [NREQ*DATA_WIDTH] operand A, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_opb_i    [NREQ*DATA_WIDTH] operand B, same packing
//   req_sub_i    [NREQ]            1 = subtract, 0 = add
//   rsp_valid_o  [NREQ]            response valid, one-hot to the owner
//   rsp_ready_i  [NREQ]            response accept per requester
//   rsp_result_o [DATA_WIDTH]      result, meaningful while rsp_valid_o != 0
//   rsp_flags_o  [3]               {overflow, underflow, zero}
//
// Modports:
//   master : requester side (APB front-end / secondary requester)
//   slave  : the sequencer
// -----------------------------------------------------------------------------
interface fpu_add_seq_ctrl_if #(
   parameter int NREQ       = 2,
   parameter int DATA_WIDTH = 32
);

   logic [NREQ-1:0]            req_valid_i;
   logic [NREQ-1:0]            req_ready_o;
   logic [NREQ*DATA_WIDTH-1:0] req_opa_i;
   logic [NREQ*DATA_WIDTH-1:0] req_opb_i;
   logic [NREQ-1:0]            req_sub_i;
   logic [NREQ-1:0]            rsp_valid_o;
   logic [NREQ-1:0]            rsp_ready_i;
   logic [DATA_WIDTH-1:0]      rsp_result_o;
   logic [2:0]                 rsp_flags_o;

   modport master (
      output req_valid_i, req_opa_i, req_opb_i, req_sub_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_flags_o
   );

   modport slave (
      input  req_valid_i, req_opa_i, req_opb_i, req_sub_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_result_o, rsp_flags_o
   );

endinterface

// File: rtl/fpu_add_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fpu_add_seq_ctrl
//
// Arbitrates one shared floating-point add/subtract datapath
// (align -> add -> normalize -> round) between NREQ requesters. The winner of
// a round-robin search has its operands latched onto dp_*_o, the datapath is
// walked through its stages with one-hot enables, and the rounded result is
// returned on a valid/ready response channel owned by that requester.
//
// Ports:
//   HCLK, HRESETn   clock (rising edge) and asynchronous active-low reset
//   req_if          slave side of fpu_add_seq_ctrl_if (request + response)
//   flush_i         synchronous abort of the in-flight operation
//   dp_opa_o/opb_o  latched operands to the datapath
//   dp_sub_o        latched op select (1 = subtract)
//   dp_*_en_o       one-hot stage enables: align, add, norm, round
//   dp_result_i     packed result from the datapath (sampled at the ROUND edge)
//   dp_flags_i      {overflow, underflow, zero} from the datapath
//   busy_o          high whenever the sequencer is not IDLE
// -----------------------------------------------------------------------------
module fpu_add_seq_ctrl #(
   parameter int NREQ        = 2,
   parameter int DATA_WIDTH  = 32,
   parameter int NORM_CYCLES = 1
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   fpu_add_seq_ctrl_if.slave     req_if,
   input  logic                  flush_i,
   output logic [DATA_WIDTH-1:0] dp_opa_o,
   output logic [DATA_WIDTH-1:0] dp_opb_o,
   output logic                  dp_sub_o,
   output logic                  dp_align_en_o,
   output logic                  dp_add_en_o,
   output logic                  dp_norm_en_o,
   output logic                  dp_round_en_o,
   input  logic [DATA_WIDTH-1:0] dp_result_i,
   input  logic [2:0]            dp_flags_i,
   output logic                  busy_o
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(NORM_CYCLES + 1);
   localparam logic [CW-1:0] NORM_LAST = CW'(NORM_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NREQ - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ALIGN,
      S_ADD,
      S_NORM,
      S_ROUND,
      S_RESP
   } state_e;

   state_e                state_q, state_d;
   logic [IW-1:0]         rr_q, rr_d;
   logic [IW-1:0]         owner_q, owner_d;
   logic [CW-1:0]         norm_cnt_q, norm_cnt_d;
   logic [DATA_WIDTH-1:0] opa_q, opb_q, result_q;
   logic                  sub_q;
   logic [2:0]            flags_q;

   logic [IW-1:0]         winner;
   logic [IW-1:0]         scan_idx;
   logic                  any_req;
   logic                  grant;
   logic                  capture;

   // -------------------------------------------------------------------------
   // Round-robin search: first valid requester at or above rr_q, wrapping.
   // -------------------------------------------------------------------------
   // NOTE: every signal written in an always_comb gets a default at the top so
   // no path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      winner   = rr_q;
      scan_idx = rr_q;
      any_req  = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = IW'((int'(rr_q) + k) % NREQ);
         if (!any_req && req_if.req_valid_i[scan_idx]) begin
            any_req = 1'b1;
            winner  = scan_idx;
         end
      end
   end

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= S_IDLE;
         rr_q       <= '0;
         owner_q    <= '0;
         norm_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         owner_q    <= owner_d;
         norm_cnt_q <= norm_cnt_d;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      owner_d    = owner_q;
      norm_cnt_d = norm_cnt_q;
      grant      = 1'b0;
      capture    = 1'b0;

      if (flush_i) begin
         // Abort wins over everything, including a grant in IDLE; the
         // round-robin pointer is left where the last grant put it.
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (any_req) begin
                  grant   = 1'b1;
                  owner_d = winner;
                  rr_d    = (winner == IDX_LAST) ? '0 : winner + 1'b1;
                  state_d = S_ALIGN;
               end
            end
            S_ALIGN: state_d = S_ADD;
            S_ADD: begin
               norm_cnt_d = '0;
               state_d    = S_NORM;
            end
            S_NORM: begin
               if (norm_cnt_q == NORM_LAST) begin
                  state_d = S_ROUND;
               end else begin
                  norm_cnt_d = norm_cnt_q + 1'b1;
               end
            end
            S_ROUND: begin
               capture = 1'b1;
               state_d = S_RESP;
            end
            S_RESP: begin
               // Only the owner's ready completes the handshake.
               if (req_if.rsp_ready_i[owner_q]) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // FSM: outputs decoded from the registered state
   // -------------------------------------------------------------------------
   always_comb begin
      req_if.req_ready_o = '0;
      req_if.rsp_valid_o = '0;
      dp_align_en_o      = 1'b0;
      dp_add_en_o        = 1'b0;
      dp_norm_en_o       = 1'b0;
      dp_round_en_o      = 1'b0;
      busy_o             = (state_q != S_IDLE);

      unique case (state_q)
         S_IDLE: begin
            if (grant) begin
               req_if.req_ready_o[winner] = 1'b1;
            end
         end
         S_ALIGN: dp_align_en_o = 1'b1;
         S_ADD:   dp_add_en_o   = 1'b1;
         S_NORM:  dp_norm_en_o  = 1'b1;
         S_ROUND: dp_round_en_o = 1'b1;
         S_RESP:  req_if.rsp_valid_o[owner_q] = 1'b1;
         default: ;
      endcase
   end

   // -------------------------------------------------------------------------
   // Operand and result registers
   // -------------------------------------------------------------------------
   // NOTE: these data registers are reset even though they are only
   // meaningful after a grant/capture, because they drive outputs that must
   // read 0 while HRESETn is low.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         opa_q    <= '0;
         opb_q    <= '0;
         sub_q    <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         // Operands move only on a grant, so they hold steady through IDLE.
         if (grant) begin
            opa_q <= req_if.req_opa_i[winner*DATA_WIDTH +: DATA_WIDTH];
            opb_q <= req_if.req_opb_i[winner*DATA_WIDTH +: DATA_WIDTH];
            sub_q <= req_if.req_sub_i[winner];
         end
         if (capture) begin
            result_q <= dp_result_i;
            flags_q  <= dp_flags_i;
         end else if (flush_i && (state_q != S_IDLE)) begin
            // A flushed operation leaves no stale result behind.
            result_q <= '0;
            flags_q  <= '0;
         end
      end
   end

   assign dp_opa_o            = opa_q;
   assign dp_opb_o            = opb_q;
   assign dp_sub_o            = sub_q;
   assign req_if.rsp_result_o = result_q;
   assign req_if.rsp_flags_o  = flags_q;

endmodule

// File: tb/tb_fpu_add_seq_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fpu_add_seq_ctrl
//
// Transaction-level bench: each operation is predicted from the round-robin
// rule and the stage latency arithmetic (grant at k=0, align at 1, add at 2,
// norm for NORM_CYCLES cycles, round next, response after that). A second
// instance built with NORM_CYCLES = 3 checks the stretched normalize phase.
// -----------------------------------------------------------------------------
module tb_fpu_add_seq_ctrl;

   localparam int NREQ    = 2;
   localparam int DW      = 32;
   localparam int NC      = 1;
   localparam int NC3     = 3;
   localparam int ROUND_K = 3 + NC;
   localparam int RESP_K  = 4 + NC;

   logic HCLK    = 1'b0;
   logic HRESETn = 1'b0;
   always #5 HCLK = ~HCLK;

   // ---------------- default build ----------------
   fpu_add_seq_ctrl_if #(.NREQ(NREQ), .DATA_WIDTH(DW)) bus ();
   logic          flush;
   logic [DW-1:0] dp_opa, dp_opb, dp_result;
   logic          dp_sub, en_align, en_add, en_norm, en_round, busy;
   logic [2:0]    dp_flags;

   fpu_add_seq_ctrl #(.NREQ(NREQ), .DATA_WIDTH(DW), .NORM_CYCLES(NC)) dut (
      .HCLK          (HCLK),
      .HRESETn       (HRESETn),
      .req_if        (bus.slave),
      .flush_i       (flush),
      .dp_opa_o      (dp_opa),
      .dp_opb_o      (dp_opb),
      .dp_sub_o      (dp_sub),
      .dp_align_en_o (en_align),
      .dp_add_en_o   (en_add),
      .dp_norm_en_o  (en_norm),
      .dp_round_en_o (en_round),
      .dp_result_i   (dp_result),
      .dp_flags_i    (dp_flags),
      .busy_o        (busy)
   );

   // ---------------- NORM_CYCLES = 3 build ----------------
   fpu_add_seq_ctrl_if #(.NREQ(NREQ), .DATA_WIDTH(DW)) bus3 ();
   logic          flush3;
   logic [DW-1:0] dp_opa3, dp_opb3, dp_result3;
   logic          dp_sub3, en_align3, en_add3, en_norm3, en_round3, busy3;
   logic [2:0]    dp_flags3;

   fpu_add_seq_ctrl #(.NREQ(NREQ), .DATA_WIDTH(DW), .NORM_CYCLES(NC3)) dut3 (
      .HCLK          (HCLK),
      .HRESETn       (HRESETn),
      .req_if        (bus3.slave),
      .flush_i       (flush3),
      .dp_opa_o      (dp_opa3),
      .dp_opb_o      (dp_opb3),
      .dp_sub_o      (dp_sub3),
      .dp_align_en_o (en_align3),
      .dp_add_en_o   (en_add3),
      .dp_norm_en_o  (en_norm3),
      .dp_round_en_o (en_round3),
      .dp_result_i   (dp_result3),
      .dp_flags_i    (dp_flags3),
      .busy_o        (busy3)
   );

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_err = 0;
   int rr_m  = 0;   // model round-robin pointer

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected {align, add, norm, round} k cycles after the grant cycle.
   function automatic logic [3:0] exp_en(input int k, input int nc);
      if (k == 1) return 4'b1000;
      if (k == 2) return 4'b0100;
      if (k >= 3 && k <= 2 + nc) return 4'b0010;
      if (k == 3 + nc) return 4'b0001;
      return 4'b0000;
   endfunction

   // First requester in mask at or above rr, wrapping.
   function automatic int pick(input logic [NREQ-1:0] mask, input int rr);
      for (int k = 0; k < NREQ; k++) begin
         if (mask[(rr + k) % NREQ]) return (rr + k) % NREQ;
      end
      return -1;
   endfunction

   // Random operands everywhere except the slot of requester w (if w >= 0).
   task automatic drive_ops(input int w, input logic [DW-1:0] fa,
                            input logic [DW-1:0] fb, input logic fs);
      for (int i = 0; i < NREQ; i++) begin
         bus.req_opa_i[i*DW +: DW] = (i == w) ? fa : DW'($urandom);
         bus.req_opb_i[i*DW +: DW] = (i == w) ? fb : DW'($urandom);
         bus.req_sub_i[i]          = (i == w) ? fs : 1'($urandom);
      end
   endtask

   // One complete operation. flush_at: -1 none, 0 flush in the IDLE cycle
   // before the grant, k>0 flush k cycles after the grant.
   task automatic run_op(input logic [NREQ-1:0] mask, input int stall, input int flush_at,
                         input logic [DW-1:0] fa, input logic [DW-1:0] fb,
                         input logic fs, input logic [DW-1:0] res);
      int         w;
      logic [2:0] flg;
      bit         done;
      w   = pick(mask, rr_m);
      flg = 3'($urandom);

      if (flush_at == 0) begin
         @(posedge HCLK); #1;
         bus.req_valid_i = mask;
         drive_ops(-1, '0, '0, 1'b0);
         flush = 1'b1;
         @(negedge HCLK);
         check("flush_idle_ready", bus.req_ready_o, 0);
         check("flush_idle_busy", busy, 0);
      end

      // Grant cycle
      @(posedge HCLK); #1;
      flush           = 1'b0;
      bus.req_valid_i = mask;
      drive_ops(w, fa, fb, fs);
      bus.rsp_ready_i = NREQ'($urandom);
      dp_result       = DW'($urandom);
      dp_flags        = 3'($urandom);
      @(negedge HCLK);
      check("grant", bus.req_ready_o, 64'(1) << w);
      check("grant_busy", busy, 0);
      check("grant_rsp_valid", bus.rsp_valid_o, 0);
      rr_m = (w + 1) % NREQ;

      done = 1'b0;
      for (int k = 1; !done; k++) begin
         @(posedge HCLK); #1;
         bus.req_valid_i    = NREQ'($urandom);
         drive_ops(-1, '0, '0, 1'b0);
         flush              = (k == flush_at);
         dp_result          = (k == ROUND_K) ? res : DW'($urandom);
         dp_flags           = (k == ROUND_K) ? flg : 3'($urandom);
         bus.rsp_ready_i    = NREQ'($urandom);
         bus.rsp_ready_i[w] = (k >= RESP_K + stall);
         @(negedge HCLK);
         check("no_grant_when_busy", bus.req_ready_o, 0);
         check("busy", busy, 1);
         check("stage_en", {en_align, en_add, en_norm, en_round}, exp_en(k, NC));
         check("dp_opa", dp_opa, fa);
         check("dp_opb", dp_opb, fb);
         check("dp_sub", dp_sub, fs);
         if (k >= RESP_K) begin
            check("rsp_valid", bus.rsp_valid_o, 64'(1) << w);
            check("rsp_result", bus.rsp_result_o, res);
            check("rsp_flags", bus.rsp_flags_o, flg);
         end else begin
            check("rsp_valid_early", bus.rsp_valid_o, 0);
         end
         done = (k == flush_at) || (k >= RESP_K + stall);
      end

      // Back in IDLE; nothing requested, operands must hold.
      @(posedge HCLK); #1;
      flush           = 1'b0;
      bus.req_valid_i = '0;
      bus.rsp_ready_i = '0;
      drive_ops(-1, '0, '0, 1'b0);
      @(negedge HCLK);
      check("idle_busy", busy, 0);
      check("idle_rsp_valid", bus.rsp_valid_o, 0);
      check("idle_stage_en", {en_align, en_add, en_norm, en_round}, 0);
      check("idle_hold_opa", dp_opa, fa);
   endtask

   initial begin
      logic [NREQ-1:0] mask;
      int              fa_k, rsp_k;

      bus.req_valid_i  = '0;
      bus.req_opa_i    = '0;
      bus.req_opb_i    = '0;
      bus.req_sub_i    = '0;
      bus.rsp_ready_i  = '0;
      flush            = 1'b0;
      dp_result        = '0;
      dp_flags         = '0;
      bus3.req_valid_i = '0;
      bus3.req_opa_i   = '0;
      bus3.req_opb_i   = '0;
      bus3.req_sub_i   = '0;
      bus3.rsp_ready_i = '0;
      flush3           = 1'b0;
      dp_result3       = 32'hC0FFEE00;
      dp_flags3        = 3'b010;

      // Reset state
      #12;
      check("rst_busy", busy, 0);
      check("rst_req_ready", bus.req_ready_o, 0);
      check("rst_rsp_valid", bus.rsp_valid_o, 0);
      check("rst_stage_en", {en_align, en_add, en_norm, en_round}, 0);
      check("rst_dp_opa", dp_opa, 0);
      check("rst_result", bus.rsp_result_o, 0);
      @(negedge HCLK);
      HRESETn = 1'b1;

      // Single add: 1.5 + 2.25 = 3.75
      run_op(2'b01, 0, -1, 32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000);

      // Round-robin with both requesters valid
      repeat (4) run_op(2'b11, 0, -1, $urandom, $urandom, 1'($urandom), $urandom);

      // Response backpressure, owner 1 stalled 7 cycles
      run_op(2'b10, 7, -1, $urandom, $urandom, 1'($urandom), $urandom);

      // Flush in NORM, then the next grant follows the flushed requester
      run_op(2'b11, 0, 3, $urandom, $urandom, 1'($urandom), $urandom);
      run_op(2'b11, 0, -1, $urandom, $urandom, 1'($urandom), $urandom);

      // Flush in IDLE blocks the grant
      run_op(2'b11, 1, 0, $urandom, $urandom, 1'($urandom), $urandom);

      // Asynchronous reset during ADD
      @(posedge HCLK); #1;
      bus.req_valid_i = 2'b01;
      drive_ops(pick(2'b01, rr_m), 32'h12345678, 32'h9ABCDEF0, 1'b1);
      @(negedge HCLK);
      check("rstadd_grant", bus.req_ready_o, 64'(1) << pick(2'b01, rr_m));
      @(posedge HCLK); #1;
      bus.req_valid_i = '0;
      @(posedge HCLK); #1;
      @(negedge HCLK);
      check("rstadd_in_add", en_add, 1);
      #2 HRESETn = 1'b0;
      #1;
      check("rstadd_busy", busy, 0);
      check("rstadd_en", {en_align, en_add, en_norm, en_round}, 0);
      check("rstadd_opa", dp_opa, 0);
      check("rstadd_sub", dp_sub, 0);
      check("rstadd_rsp_valid", bus.rsp_valid_o, 0);
      @(posedge HCLK); #2;
      HRESETn = 1'b1;
      rr_m    = 0;
      bus.rsp_ready_i = '1;
      for (int i = 0; i < 6; i++) begin
         @(negedge HCLK);
         check("post_rst_busy", busy, 0);
         check("post_rst_rsp_valid", bus.rsp_valid_o, 0);
      end

      // Randomized operations
      for (int n = 0; n < 40; n++) begin
         mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         fa_k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, RESP_K + 1) : -1;
         run_op(mask, $urandom_range(0, 3), fa_k, $urandom, $urandom, 1'($urandom), $urandom);
      end

      // NORM_CYCLES = 3 build: normalize held 3 cycles, response at grant+7
      @(posedge HCLK); #1;
      bus3.req_valid_i = 2'b01;
      bus3.rsp_ready_i = '1;
      bus3.req_opa_i   = {32'h0, 32'h3F800000};
      @(negedge HCLK);
      check("n3_grant", bus3.req_ready_o, 1);
      rsp_k = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge HCLK); #1;
         bus3.req_valid_i = '0;
         @(negedge HCLK);
         check("n3_stage_en", {en_align3, en_add3, en_norm3, en_round3}, exp_en(k, NC3));
         if (bus3.rsp_valid_o != '0 && rsp_k == 0) begin
            rsp_k = k;
            check("n3_rsp_result", bus3.rsp_result_o, 32'hC0FFEE00);
         end
      end
      check("n3_rsp_latency", rsp_k, 7);
      check("n3_back_idle", busy3, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
